// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : MEM pipeline stage that waits for the data-SRAM response, aligns
//            and extends load data, and drops responses of flushed requests.
//            Build option MS_LD_FWD_EN lets ID forward load data on arrival.
// Revision : 1.0
// ============================================================================
module mem_stage #(
  parameter int CANCEL_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic        es_rf_we,
  input  logic [4:0]  es_rf_waddr,
  input  logic [31:0] es_result,
  input  logic        es_res_from_mem,
  input  logic        es_mem_req,
  input  logic [4:0]  es_ld_inst,
  input  logic        es_csr_re,
  input  logic [85:0] es_ex_zip,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  input  logic        wb_ex,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic        ms_rf_we,
  output logic [4:0]  ms_rf_waddr,
  output logic [31:0] ms_final_result,
  output logic        ms_res_from_mem,
  output logic        ms_data_pending,
  output logic        ms_csr_re,
  output logic        ms_ex,
  output logic [85:0] ms_ex_zip
);

  localparam logic [CANCEL_W-1:0] C_CANCEL_MAX = '1;

  logic                r_ms_valid;
  logic [31:0]         r_pc;
  logic                r_rf_we;
  logic [4:0]          r_rf_waddr;
  logic [31:0]         r_result;
  logic                r_res_from_mem;
  logic                r_mem_req;
  logic [4:0]          r_ld_inst;
  logic                r_csr_re;
  logic [85:0]         r_ex_zip;
  logic                r_buf_vld;
  logic [31:0]         r_buf_data;
  logic [CANCEL_W-1:0] r_cancel_cnt;

  logic        w_ex;
  logic        w_wait;
  logic        w_data_ok_eff;
  logic        w_drop;
  logic        w_ready_go;
  logic        w_allowin;
  logic        w_to_ws;
  logic        w_accept;
  logic        w_xfer;
  logic        w_cancel_inc;
  logic [31:0] w_rdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_ex          = r_ms_valid & (|r_ex_zip[6:0]);
  assign w_wait        = r_ms_valid & r_mem_req & ~w_ex;
  assign w_data_ok_eff = data_sram_data_ok & (r_cancel_cnt == '0);
  assign w_drop        = data_sram_data_ok & (r_cancel_cnt != '0);
  assign w_ready_go    = ~w_wait | w_data_ok_eff | r_buf_vld;
  assign w_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
  assign w_to_ws       = r_ms_valid & w_ready_go & ~wb_ex;
  assign w_accept      = es_to_ms_valid & w_allowin;
  assign w_xfer        = w_to_ws & ws_allowin;
  // A same-cycle response that is itself being dropped does not satisfy the
  // flushed request, so that request still needs its own cancel slot.
  assign w_cancel_inc  = wb_ex & w_wait & ~r_buf_vld & ~w_data_ok_eff;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
    end else if (wb_ex) begin
      r_ms_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc           <= 32'h0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= 5'h0;
      r_result       <= 32'h0;
      r_res_from_mem <= 1'b0;
      r_mem_req      <= 1'b0;
      r_ld_inst      <= 5'h0;
      r_csr_re       <= 1'b0;
      r_ex_zip       <= 86'h0;
    end else if (w_accept) begin
      r_pc           <= es_pc;
      r_rf_we        <= es_rf_we;
      r_rf_waddr     <= es_rf_waddr;
      r_result       <= es_result;
      r_res_from_mem <= es_res_from_mem;
      r_mem_req      <= es_mem_req;
      r_ld_inst      <= es_ld_inst;
      r_csr_re       <= es_csr_re;
      r_ex_zip       <= es_ex_zip;
    end
  end

  // Holds a response that arrived while WB was stalling this stage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_vld  <= 1'b0;
      r_buf_data <= 32'h0;
    end else if (wb_ex || w_xfer) begin
      r_buf_vld  <= 1'b0;
    end else if (w_data_ok_eff && r_ms_valid && !ws_allowin) begin
      r_buf_vld  <= 1'b1;
      r_buf_data <= data_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cancel_cnt <= '0;
    end else begin
      case ({w_cancel_inc, w_drop})
        2'b10: if (r_cancel_cnt != C_CANCEL_MAX) r_cancel_cnt <= r_cancel_cnt + 1'b1;
        2'b01: r_cancel_cnt <= r_cancel_cnt - 1'b1;
        default: r_cancel_cnt <= r_cancel_cnt;
      endcase
    end
  end

  assign w_rdata = r_buf_vld ? r_buf_data : data_sram_rdata;
  assign w_half  = r_result[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_byte = w_rdata[7:0];
    case (r_result[1:0])
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      2'd3:    w_byte = w_rdata[31:24];
      default: w_byte = w_rdata[7:0];
    endcase
  end

  // ld_inst = {ld_b, ld_bu, ld_h, ld_hu, ld_w}
  always_comb begin
    w_load_data = w_rdata;
    if (r_ld_inst[4]) begin
      w_load_data = {{24{w_byte[7]}}, w_byte};
    end else if (r_ld_inst[3]) begin
      w_load_data = {24'h0, w_byte};
    end else if (r_ld_inst[2]) begin
      w_load_data = {{16{w_half[15]}}, w_half};
    end else if (r_ld_inst[1]) begin
      w_load_data = {16'h0, w_half};
    end else if (r_ld_inst[0]) begin
      w_load_data = w_rdata;
    end
  end

  assign ms_allowin      = w_allowin;
  assign ms_to_ws_valid  = w_to_ws;
  assign ms_pc           = r_pc;
  assign ms_rf_we        = r_rf_we & ~w_ex;
  assign ms_rf_waddr     = r_rf_waddr;
  assign ms_final_result = r_res_from_mem ? w_load_data : r_result;
  assign ms_res_from_mem = r_ms_valid & r_res_from_mem;
  assign ms_csr_re       = r_csr_re;
  assign ms_ex           = w_ex;
  assign ms_ex_zip       = r_ex_zip;

`ifdef MS_LD_FWD_EN
  assign ms_data_pending = r_ms_valid & r_res_from_mem & ~(w_data_ok_eff | r_buf_vld);
`else
  assign ms_data_pending = r_ms_valid & r_res_from_mem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0
// ============================================================================
module tb_mem_stage;

  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_BU = 5'b01000;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b00010;
  localparam logic [4:0] LD_W  = 5'b00001;
`ifdef MS_LD_FWD_EN
  localparam logic PEND_ON_DATA = 1'b0;
`else
  localparam logic PEND_ON_DATA = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_result;
  logic        es_res_from_mem;
  logic        es_mem_req;
  logic [4:0]  es_ld_inst;
  logic        es_csr_re;
  logic [85:0] es_ex_zip;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        wb_ex;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_final_result;
  logic        ms_res_from_mem;
  logic        ms_data_pending;
  logic        ms_csr_re;
  logic        ms_ex;
  logic [85:0] ms_ex_zip;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.CANCEL_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
    .es_result(es_result), .es_res_from_mem(es_res_from_mem),
    .es_mem_req(es_mem_req), .es_ld_inst(es_ld_inst), .es_csr_re(es_csr_re),
    .es_ex_zip(es_ex_zip),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ws_allowin(ws_allowin), .wb_ex(wb_ex),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_final_result(ms_final_result),
    .ms_res_from_mem(ms_res_from_mem), .ms_data_pending(ms_data_pending),
    .ms_csr_re(ms_csr_re), .ms_ex(ms_ex), .ms_ex_zip(ms_ex_zip)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [85:0] obs, input logic [85:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one load to MEM; returns with the load latched in MEM.
  task automatic send_load(input logic [4:0] ld, input logic [31:0] addr);
    es_to_ms_valid  = 1'b1;
    es_pc           = 32'h1c00_0100;
    es_rf_we        = 1'b1;
    es_rf_waddr     = 5'd7;
    es_result       = addr;
    es_res_from_mem = 1'b1;
    es_mem_req      = 1'b1;
    es_ld_inst      = ld;
    es_csr_re       = 1'b0;
    es_ex_zip       = 86'h0;
    step();
    es_to_ms_valid  = 1'b0;
    es_mem_req      = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [4:0] ld, input logic [31:0] addr,
                         input int delay, input logic [31:0] rdata, input logic [31:0] exp);
    send_load(ld, addr);
    for (int k = 0; k < delay; k++) begin
      #1;
      chk({tag, "_wait_valid"}, ms_to_ws_valid, 1'b0);
      chk({tag, "_wait_pend"}, ms_data_pending, 1'b1);
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rdata;
    #1;
    chk({tag, "_valid"}, ms_to_ws_valid, 1'b1);
    chk({tag, "_data"}, ms_final_result, exp);
    chk({tag, "_pend"}, ms_data_pending, PEND_ON_DATA);
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    chk({tag, "_gone"}, ms_to_ws_valid, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    es_to_ms_valid = 1'b0; es_pc = 32'h0; es_rf_we = 1'b0; es_rf_waddr = 5'h0;
    es_result = 32'h0; es_res_from_mem = 1'b0; es_mem_req = 1'b0; es_ld_inst = 5'h0;
    es_csr_re = 1'b0; es_ex_zip = 86'h0; data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0; ws_allowin = 1'b1; wb_ex = 1'b0;
    step(); step();
    chk("rst_valid", ms_to_ws_valid, 1'b0);
    chk("rst_pc", ms_pc, 32'h0);
    chk("rst_rf_we", ms_rf_we, 1'b0);
    chk("rst_result", ms_final_result, 32'h0);
    chk("rst_zip", ms_ex_zip, 86'h0);
    chk("rst_allowin", ms_allowin, 1'b1);
    chk("rst_pend", ms_data_pending, 1'b0);
    resetn = 1'b1;
    step();

    // ALU op passes through in one cycle
    es_to_ms_valid = 1'b1; es_pc = 32'h1c00_0000; es_rf_we = 1'b1; es_rf_waddr = 5'd3;
    es_result = 32'h5; es_res_from_mem = 1'b0; es_mem_req = 1'b0; es_csr_re = 1'b1;
    step();
    es_to_ms_valid = 1'b0; es_csr_re = 1'b0;
    #1;
    chk("add_valid", ms_to_ws_valid, 1'b1);
    chk("add_result", ms_final_result, 32'h5);
    chk("add_rf_we", ms_rf_we, 1'b1);
    chk("add_waddr", ms_rf_waddr, 5'd3);
    chk("add_pc", ms_pc, 32'h1c00_0000);
    chk("add_csr_re", ms_csr_re, 1'b1);
    chk("add_pend", ms_data_pending, 1'b0);
    step();
    chk("add_drain", ms_to_ws_valid, 1'b0);

    do_load("ldb_1003", LD_B, 32'h1003, 2, 32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load("ldbu_1", LD_BU, 32'h1, 0, 32'h0000_8000, 32'h0000_0080);
    do_load("ldb_2", LD_B, 32'h2, 0, 32'h007F_0000, 32'h0000_007F);
    do_load("ldh_0", LD_H, 32'h0, 1, 32'h1111_8234, 32'hFFFF_8234);
    do_load("ldw", LD_W, 32'h8, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Response arrives while WB stalls: buffered until WB accepts
    send_load(LD_HU, 32'h2);
    ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8001_1234;
    #1;
    chk("buf_live_valid", ms_to_ws_valid, 1'b1);
    chk("buf_live_data", ms_final_result, 32'h0000_8001);
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("buf_vld", dut.r_buf_vld, 1'b1);
    chk("buf_data", ms_final_result, 32'h0000_8001);
    chk("buf_allowin", ms_allowin, 1'b0);
    step();
    ws_allowin = 1'b1;
    #1;
    chk("buf_rel_valid", ms_to_ws_valid, 1'b1);
    chk("buf_rel_data", ms_final_result, 32'h0000_8001);
    chk("buf_rel_allowin", ms_allowin, 1'b1);
    step();
    chk("buf_clear", dut.r_buf_vld, 1'b0);
    chk("buf_drain", ms_to_ws_valid, 1'b0);

    // Flush while waiting: the stale response must be dropped
    send_load(LD_W, 32'h10);
    wb_ex = 1'b1;
    #1;
    chk("flush_valid", ms_to_ws_valid, 1'b0);
    step();
    wb_ex = 1'b0;
    #1;
    chk("flush_cnt", dut.r_cancel_cnt, 2'd1);
    chk("flush_allowin", ms_allowin, 1'b1);
    send_load(LD_W, 32'h20);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
    #1;
    chk("drop_valid", ms_to_ws_valid, 1'b0);
    step();
    data_sram_data_ok = 1'b0;
    #1;
    chk("drop_cnt", dut.r_cancel_cnt, 2'd0);
    chk("drop_still_wait", ms_to_ws_valid, 1'b0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
    #1;
    chk("own_valid", ms_to_ws_valid, 1'b1);
    chk("own_data", ms_final_result, 32'h2222_2222);
    step();
    data_sram_data_ok = 1'b0;

    // Address-error load: exception skips the wait and kills the write
    es_to_ms_valid = 1'b1; es_res_from_mem = 1'b1; es_mem_req = 1'b1; es_ld_inst = LD_W;
    es_result = 32'h1001; es_rf_we = 1'b1; es_ex_zip = 86'h1;
    step();
    es_to_ms_valid = 1'b0; es_mem_req = 1'b0; es_ex_zip = 86'h0;
    #1;
    chk("ale_ex", ms_ex, 1'b1);
    chk("ale_rf_we", ms_rf_we, 1'b0);
    chk("ale_valid", ms_to_ws_valid, 1'b1);
    chk("ale_zip", ms_ex_zip, 86'h1);
    step();
    chk("ale_drain", ms_to_ws_valid, 1'b0);
    chk("ale_ex_gone", ms_ex, 1'b0);

    // Cancel counter saturates at 3
    for (int i = 1; i <= 4; i++) begin
      send_load(LD_W, 32'h40);
      wb_ex = 1'b1;
      step();
      wb_ex = 1'b0;
      #1;
      chk($sformatf("sat_cnt_%0d", i), dut.r_cancel_cnt, (i > 3) ? 2'd3 : i[1:0]);
    end

    // Asynchronous reset while a load waits
    send_load(LD_B, 32'h3);
    #1;
    chk("arst_pre_pend", ms_data_pending, 1'b1);
    resetn = 1'b0;
    #1;
    chk("arst_valid", ms_to_ws_valid, 1'b0);
    chk("arst_pc", ms_pc, 32'h0);
    chk("arst_rf_we", ms_rf_we, 1'b0);
    chk("arst_res_mem", ms_res_from_mem, 1'b0);
    chk("arst_pend", ms_data_pending, 1'b0);
    chk("arst_result", ms_final_result, 32'h0);
    chk("arst_cnt", dut.r_cancel_cnt, 2'd0);
    step();
    resetn = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
